// File: rtl/sorter_pkg.sv
// Shared types and key comparison for the streaming frame sorter.
package sorter_pkg;

  localparam int unsigned KEY_W = 64;

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  // Keys arrive pre-extended to KEY_W so that one function serves every sample width.
  function automatic logic precedes(input logic [KEY_W-1:0] x,
                                    input logic [KEY_W-1:0] c,
                                    input logic             signed_mode,
                                    input logic             descend);
    logic lt;
    logic gt;
    if (signed_mode) begin
      lt = $signed(x) < $signed(c);
      gt = $signed(x) > $signed(c);
    end else begin
      lt = x < c;
      gt = x > c;
    end
    return descend ? gt : lt;
  endfunction

endpackage

// File: rtl/sorter_cell.sv
// One storage cell of the sorter: key/occupied registers plus the local insertion compare.
module sorter_cell
  import sorter_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int          SIGNED  = 0,
  parameter int          DESCEND = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          insert,
  input  logic          shift,
  input  logic [DW-1:0] in_data,
  input  logic          prev_t,
  input  logic [DW-1:0] prev_key,
  input  logic          prev_occ,
  input  logic [DW-1:0] next_key,
  input  logic          next_occ,
  output logic          t,
  output logic [DW-1:0] key,
  output logic          occ
);

  logic [KEY_W-1:0] x_w;
  logic [KEY_W-1:0] c_w;

  always_comb begin
    if (SIGNED != 0) begin
      x_w = KEY_W'($signed(in_data));
      c_w = KEY_W'($signed(key));
    end else begin
      x_w = KEY_W'(in_data);
      c_w = KEY_W'(key);
    end
    t = !occ || precedes(x_w, c_w, SIGNED != 0, DESCEND != 0);
  end

  // Key content is meaningless while unoccupied, so it carries no reset.
  always_ff @(posedge clk) begin
    if (insert) begin
      key <= prev_t ? prev_key : (t ? in_data : key);
    end else if (shift) begin
      key <= next_key;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ <= 1'b0;
    end else if (insert) begin
      occ <= prev_t ? prev_occ : (t ? 1'b1 : occ);
    end else if (shift) begin
      occ <= next_occ;
    end
  end

endmodule

// File: rtl/sequence_sorter_n.sv
// Streaming frame sorter: insertion-sorts up to DEPTH samples on arrival, then drains them in order.
module sequence_sorter_n
  import sorter_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int          SIGNED  = 0,
  parameter int          DESCEND = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   key [DEPTH];
  logic [DEPTH-1:0] occ;
  logic [DEPTH-1:0] t;
  logic            accept;
  logic            pop;
  logic            frame_end;

  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign frame_end = accept && (in_last || (cnt == CW'(DEPTH - 1)));

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    logic [DW-1:0] pk;
    logic [DW-1:0] nk;
    logic          pt;
    logic          po;
    logic          no;

    if (g == 0) begin : g_head
      assign pk = '0;
      assign pt = 1'b0;
      assign po = 1'b0;
    end else begin : g_body
      assign pk = key[g-1];
      assign pt = t[g-1];
      assign po = occ[g-1];
    end

    if (g == DEPTH - 1) begin : g_tail
      assign nk = key[g];
      assign no = 1'b0;
    end else begin : g_inner
      assign nk = key[g+1];
      assign no = occ[g+1];
    end

    sorter_cell #(
      .DW      (DW),
      .SIGNED  (SIGNED),
      .DESCEND (DESCEND)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .insert   (accept),
      .shift    (pop),
      .in_data  (in_data),
      .prev_t   (pt),
      .prev_key (pk),
      .prev_occ (po),
      .next_key (nk),
      .next_occ (no),
      .t        (t[g]),
      .key      (key[g]),
      .occ      (occ[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FILL;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FILL:  if (frame_end)          state_nx = S_DRAIN;
      S_DRAIN: if (pop && out_last)    state_nx = S_FILL;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = key[0];
    case (state)
      S_FILL:  in_ready = 1'b1;
      S_DRAIN: begin
        out_valid = occ[0];
        out_last  = occ[0] && !occ[1];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == S_DRAIN && pop && out_last) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_sequence_sorter_n.sv
// Directed bench driving unsigned, signed and descending sorters in lockstep against a scoreboard.
module tb_sequence_sorter_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       out_ready;

  logic [7:0] od [3];
  logic       ov [3];
  logic       ol [3];
  logic       ir [3];

  int checks = 0;
  int passes = 0;

  logic [8:0] exp_q [3][$];
  logic [7:0] cur [$];

  always #5 clk = ~clk;

  sequence_sorter_n #(.DW(8), .DEPTH(4), .SIGNED(0), .DESCEND(0)) u_uns (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(ir[0]), .out_data(od[0]), .out_valid(ov[0]), .out_last(ol[0]), .out_ready(out_ready));

  sequence_sorter_n #(.DW(8), .DEPTH(4), .SIGNED(1), .DESCEND(0)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(ir[1]), .out_data(od[1]), .out_valid(ov[1]), .out_last(ol[1]), .out_ready(out_ready));

  sequence_sorter_n #(.DW(8), .DEPTH(4), .SIGNED(0), .DESCEND(1)) u_dsc (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(ir[2]), .out_data(od[2]), .out_valid(ov[2]), .out_last(ol[2]), .out_ready(out_ready));

  task automatic check(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s[%0d]: got %0h expected %0h", tag, inst, obs, exp);
  endtask

  function automatic bit prec(input logic [7:0] x, input logic [7:0] c, input bit s, input bit d);
    int xi;
    int ci;
    xi = s ? int'($signed(x)) : int'(x);
    ci = s ? int'($signed(c)) : int'(c);
    return d ? (xi > ci) : (xi < ci);
  endfunction

  // Reference stable sort of the current frame for each instance's mode.
  task automatic close_frame();
    for (int m = 0; m < 3; m++) begin
      logic [7:0] res [$];
      bit s;
      bit d;
      s = (m == 1);
      d = (m == 2);
      res.delete();
      foreach (cur[k]) begin
        int j;
        j = 0;
        while (j < res.size() && !prec(cur[k], res[j], s, d)) j++;
        res.insert(j, cur[k]);
      end
      foreach (res[k]) exp_q[m].push_back({(k == res.size() - 1) ? 1'b1 : 1'b0, res[k]});
    end
    cur.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check("in_ready_fill", i, 32'(ir[i]), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    cur.push_back(d);
    if (last || cur.size() == 4) close_frame();
  endtask

  task automatic gap();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input logic [15:0] pat, input int plen, input int max_pops);
    int pops;
    int cyc;
    pops = 0;
    cyc  = 0;
    while (exp_q[0].size() > 0 && pops < max_pops) begin
      @(negedge clk);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = (cyc < plen) ? pat[cyc] : 1'b1;
      for (int i = 0; i < 3; i++) begin
        check("in_ready_drain", i, 32'(ir[i]), 32'd0);
        check("out_valid", i, 32'(ov[i]), 32'd1);
        if (exp_q[i].size() > 0) begin
          check("out_data", i, 32'(od[i]), 32'(exp_q[i][0][7:0]));
          check("out_last", i, 32'(ol[i]), 32'(exp_q[i][0][8]));
        end
      end
      if (out_ready) begin
        pops++;
        for (int i = 0; i < 3; i++) if (exp_q[i].size() > 0) void'(exp_q[i].pop_front());
      end
      cyc++;
    end
  endtask

  task automatic after_drain();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("idle_valid", i, 32'(ov[i]), 32'd0);
      check("idle_last", i, 32'(ol[i]), 32'd0);
      check("idle_ready", i, 32'(ir[i]), 32'd1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", i, 32'(ir[i]), 32'd1);
      check("rst_valid", i, 32'(ov[i]), 32'd0);
      check("rst_last", i, 32'(ol[i]), 32'd0);
    end
    rst_n = 1'b1;

    send(8'd7, 1'b0); send(8'd3, 1'b0); send(8'd9, 1'b0); send(8'd1, 1'b0);
    drain(16'hFFFF, 0, 100);
    after_drain();

    send(8'h05, 1'b0); send(8'hFE, 1'b0); send(8'h80, 1'b0); send(8'h7F, 1'b0);
    drain(16'hFFFF, 0, 100);
    after_drain();

    send(8'd200, 1'b0); send(8'd10, 1'b1);
    drain(16'hFFFF, 0, 100);
    after_drain();

    send(8'd4, 1'b0); send(8'd2, 1'b0); send(8'd8, 1'b0); send(8'd6, 1'b0);
    drain(16'b1011_0010, 8, 100);
    after_drain();

    send(8'd5, 1'b0); send(8'd5, 1'b0); gap(); send(8'd5, 1'b0); send(8'd2, 1'b1);
    drain(16'hFFFF, 0, 100);
    after_drain();

    send(8'd8, 1'b0); send(8'd6, 1'b0); send(8'd4, 1'b0); send(8'd2, 1'b0);
    drain(16'hFFFF, 0, 2);
    @(negedge clk);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd99;
    in_last   = 1'b1;
    for (int i = 0; i < 3; i++) exp_q[i].delete();
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("post_rst_valid", i, 32'(ov[i]), 32'd0);
      check("post_rst_ready", i, 32'(ir[i]), 32'd1);
    end

    out_ready = 1'b1;
    send(8'd3, 1'b0); send(8'd1, 1'b1);
    drain(16'hFFFF, 0, 100);
    after_drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sequence_sorter_n.md
# sequence_sorter_n

Parametrised streaming frame sorter. It accepts a frame of up to `DEPTH` samples over a valid/ready input, insertion-sorts them on arrival in a register array, then drains the frame in sorted order over a valid/ready output. It generalises the fixed 4-deep comparator-chain sorter with the following additions:
- configurable depth;
- signed and descending modes;
- variable-length frames;
- backpressure.

It sits between the sample source and downstream statistics/median logic.

## Interface
- `DW`, 8, sample width in bits (≥1).
- `DEPTH`, 4, maximum samples per frame (≥2).
- `SIGNED`, 0, 1 = two's-complement compare, 0 = unsigned compare.
- `DESCEND`, 0, 1 = output largest first, 0 = smallest first.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `in_data`  in  DW  sample.
- `in_valid`  in  1  sample present.
- `in_last`  in  1  sample closes the frame early; qualified by the input handshake.
- `in_ready`  out  1  block accepts a sample.
- `out_data`  out  DW  sorted sample.
- `out_valid`  out  1  `out_data` is valid.
- `out_last`  out  1  final sample of the frame.
- `out_ready`  in  1  sink accepts the sample.

## Operation
- **Storage.** `DEPTH` cells, each holding a key `c[i]` and an `occ[i]` flag.
  - Occupied cells are always contiguous from index 0 and always sorted.
- **Precedence predicate.** `p(x,c)` is true when `x` strictly precedes `c`:
  - `x < c` when `DESCEND=0`, `x > c` when `DESCEND=1`;
  - signedness is set by `SIGNED`.
- **FILL state.** `in_ready=1`. On each accept (`in_valid && in_ready`), insertion completes in a single cycle:
  - `t[i] = !occ[i] || p(in_data, c[i])`;
  - `c[i] <= t[i-1] ? c[i-1] : (t[i] ? in_data : c[i])`, with `t[-1]=0`;
  - `occ` shifts in a 1 at the insertion point.
  - Equal keys keep arrival order (stable sort).
- **Frame count.** `cnt` has width `$clog2(DEPTH+1)` and increments on every accept.
- **FILL → DRAIN.** Taken on the accept where `cnt` reaches `DEPTH`, or on an accept with `in_last=1`, whichever comes first. `in_last` on the `DEPTH`-th sample is equivalent.
- **DRAIN state.**
  - `in_ready=0`.
  - `out_valid=occ[0]`, `out_data=c[0]`.
  - `out_last=occ[0] && !occ[1]`.
  - On an output handshake, every cell shifts down: `c[i] <= c[i+1]`, `occ[i] <= occ[i+1]`, and `occ[DEPTH-1] <= 0`.
- **DRAIN → FILL.** Taken on the handshake with `out_last=1`. `cnt` clears on this transition.
- **Backpressure.** With `out_ready=0`, `out_data`, `out_valid` and `out_last` hold stable. A sample is never dropped or duplicated.
- **Reset.** `rst_n=0` at a clock edge clears all `occ` bits and `cnt` and forces FILL. This applies mid-FILL and mid-DRAIN alike; a partial frame is discarded.
- **Values.** `c[]` content is don't-care when unoccupied and is not reset.

## Timing
- Reset values, valid from the first edge with `rst_n=0`: `in_ready=1`, `out_valid=0`, `out_last=0`, `out_data` = don't-care.
  - Inputs presented while `rst_n=0` are ignored.
- Insertion latency is 1 cycle. Input throughput is 1 sample/cycle in FILL.
- `out_valid` rises in the cycle after the frame-closing accept.
- With `out_ready` held at 1, a frame of `k` samples occupies exactly `2k` cycles.
- FILL and DRAIN do not overlap. `in_ready` rises in the cycle after the `out_last` handshake.
- All outputs are functions of registers only: there is no combinational path from inputs to outputs.

## Structure
- Package `sorter_pkg` holds:
  - the state enum `{S_FILL, S_DRAIN}`;
  - the compare function `precedes(x, c, signed_mode, descend)`.
- Sub-module `sorter_cell`: one cell containing the key/occupied registers and the local `t[i]` compare. It takes neighbour inputs and shift and insert controls.
  - The top level generates `DEPTH` instances plus the FSM and counter.

## Test plan
- **Unsigned sort.** `DEPTH=4`, unsigned. Input 7,3,9,1 with `out_ready=1` → output 1,3,7,9; `out_last` only on 9; first `out_valid` one cycle after 1 is accepted.
- **Signed sort.** `SIGNED=1`. Input 0x05,0xFE,0x80,0x7F → output 0x80,0xFE,0x05,0x7F.
- **Early frame close.** Input 200, then 10 with `in_last=1` → output 10,200; `out_last` on 200; `in_ready=0` until the 200 handshake, and 1 on the next cycle.
- **Backpressure.** Input 4,2,8,6, then `out_ready` pattern 0,1,0,0,1,1,0,1 → output 2,4,6,8 with data stable while stalled and `in_ready=0` throughout DRAIN.
- **Duplicates and descending mode.**
  - Input 5,5,5,2 → 2,5,5,5.
  - `DESCEND=1` with input 7,3,9,1 → 9,7,3,1.
- **Reset mid-drain.** Pulse `rst_n=0` for 1 cycle after 2 of 4 outputs → `out_valid=0` and `in_ready=1` on the following cycle. The next frame 3,1 with `in_last` → output 1,3 with no stale samples.
